bus_script_player: RTL and testbench

//  Synthesizable scripted bus driver for bench and FPGA bring-up of top8227.

---
 rtl/bus_script_player.sv | 176 +++++++++++++++++
 tb/tb_bus_script_player.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_script_player.sv
// Scripted bus driver: holds the CPU in reset, then plays one script byte per clock on its data input.
// Optional address checking against per-step expectations is built when PLAYER_ADDR_CHECK_EN is defined.
module bus_script_player #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 16,
    parameter int DEPTH        = 32,
    parameter int RESET_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       load_en,
    input  logic [$clog2(DEPTH)-1:0]   load_idx,
    input  logic [DATA_W-1:0]          load_data,
    input  logic [ADDR_W-1:0]          load_addr,
    input  logic                       load_chk,
    input  logic [$clog2(DEPTH):0]     script_len,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          addr_bus,
    output logic                       cpu_nrst,
    output logic [DATA_W-1:0]          data_out,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   step_idx,
    output logic [7:0]                 mismatch_cnt,
    output logic [$clog2(DEPTH)-1:0]   first_mis_idx
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int LEN_W  = IDX_W + 1;
    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET_HOLD,
        S_PLAY,
        S_DONE
    } state_t;

    state_t              r_state;
    logic                r_cpu_nrst;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_busy;
    logic                r_done;
    logic [IDX_W-1:0]    r_step_idx;
    logic [7:0]          r_mis_cnt;
    logic [IDX_W-1:0]    r_first_mis;
    logic [LEN_W-1:0]    r_len;
    logic [HOLD_W-1:0]   r_hold_cnt;

    logic [DATA_W-1:0]   r_data_mem [DEPTH];

    logic                w_load_ok;
    logic                w_start_ok;
    logic                w_last;
    logic                w_mis;
    logic [IDX_W-1:0]    w_next_idx;
    logic [LEN_W-1:0]    w_clamped_len;

    // Loads are refused while a run is in progress so the script cannot change under playback.
    assign w_load_ok     = load_en && !r_busy;
    assign w_start_ok    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_next_idx    = r_step_idx + IDX_W'(1);
    assign w_last        = ({1'b0, r_step_idx} + LEN_W'(1)) == r_len;
    assign w_clamped_len = (script_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : script_len;

    // NOTE: script storage has no reset; it is plain RAM and keeps its contents across nrst.
    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_data_mem[load_idx] <= load_data;
        end
    end

`ifdef PLAYER_ADDR_CHECK_EN
    logic [ADDR_W-1:0]   r_addr_mem [DEPTH];
    logic [DEPTH-1:0]    r_chk_mem;

    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_addr_mem[load_idx] <= load_addr;
            r_chk_mem[load_idx]  <= load_chk;
        end
    end

    assign w_mis = (r_state == S_PLAY) && r_chk_mem[r_step_idx]
                   && (addr_bus != r_addr_mem[r_step_idx]);
`else
    logic w_unused_check_inputs;
    assign w_unused_check_inputs = ^{load_addr, load_chk, addr_bus};
    assign w_mis = 1'b0;
`endif

    // NOTE: all state and outputs are updated with non-blocking assignments in one clocked block.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= S_IDLE;
            r_cpu_nrst  <= 1'b0;
            r_data_out  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_step_idx  <= '0;
            r_mis_cnt   <= '0;
            r_first_mis <= '1;
            r_len       <= '0;
            r_hold_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        r_state     <= S_RESET_HOLD;
                        r_len       <= w_clamped_len;
                        r_mis_cnt   <= '0;
                        r_first_mis <= '1;
                        r_hold_cnt  <= HOLD_W'(RESET_CYCLES - 1);
                        r_cpu_nrst  <= 1'b0;
                        r_data_out  <= '0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                    end
                end

                S_RESET_HOLD: begin
                    if (r_hold_cnt == '0) begin
                        r_cpu_nrst <= 1'b1;
                        if (r_len == '0) begin
                            r_state    <= S_DONE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_data_out <= '0;
                        end else begin
                            // First byte is registered here so it is valid on the first CPU cycle.
                            r_state    <= S_PLAY;
                            r_step_idx <= '0;
                            r_data_out <= r_data_mem[0];
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                    end
                end

                S_PLAY: begin
                    if (w_mis) begin
                        if (r_mis_cnt != 8'hFF) begin
                            r_mis_cnt <= r_mis_cnt + 8'd1;
                        end
                        if (r_first_mis == '1) begin
                            r_first_mis <= r_step_idx;
                        end
                    end
                    if (w_last) begin
                        // step_idx is left on the final step rather than wrapping.
                        r_state    <= S_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_data_out <= '0;
                    end else begin
                        r_step_idx <= w_next_idx;
                        r_data_out <= r_data_mem[w_next_idx];
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_nrst      = r_cpu_nrst;
    assign data_out      = r_data_out;
    assign busy          = r_busy;
    assign done          = r_done;
    assign step_idx      = r_step_idx;
    assign mismatch_cnt  = r_mis_cnt;
    assign first_mis_idx = r_first_mis;

endmodule

// File: tb/tb_bus_script_player.sv
// Self-checking bench for bus_script_player: scoreboard of expected played bytes plus run-level checks.
// Expected mismatch results depend on whether PLAYER_ADDR_CHECK_EN is defined.
module tb_bus_script_player;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 32;
    localparam int IDX_W  = 5;
    localparam int RST_CY = 2;

    logic               clk;
    logic               nrst;
    logic               load_en;
    logic [IDX_W-1:0]   load_idx;
    logic [DATA_W-1:0]  load_data;
    logic [ADDR_W-1:0]  load_addr;
    logic               load_chk;
    logic [IDX_W:0]     script_len;
    logic               start;
    logic [ADDR_W-1:0]  addr_bus;
    logic               cpu_nrst;
    logic [DATA_W-1:0]  data_out;
    logic               busy;
    logic               done;
    logic [IDX_W-1:0]   step_idx;
    logic [7:0]         mismatch_cnt;
    logic [IDX_W-1:0]   first_mis_idx;

    bus_script_player #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_CYCLES(RST_CY)
    ) dut (
        .clk(clk), .nrst(nrst), .load_en(load_en), .load_idx(load_idx),
        .load_data(load_data), .load_addr(load_addr), .load_chk(load_chk),
        .script_len(script_len), .start(start), .addr_bus(addr_bus),
        .cpu_nrst(cpu_nrst), .data_out(data_out), .busy(busy), .done(done),
        .step_idx(step_idx), .mismatch_cnt(mismatch_cnt), .first_mis_idx(first_mis_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  idx;
    } exp_t;

    exp_t               exp_q[$];
    logic [DATA_W-1:0]  sh_data [DEPTH];
    logic [ADDR_W-1:0]  cpu_addr [DEPTH];
    int                 checks;
    int                 failures;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int idx, input logic [7:0] data, input logic [15:0] addr,
                        input logic chk);
        @(negedge clk);
        load_en   = 1'b1;
        load_idx  = IDX_W'(idx);
        load_data = data;
        load_addr = addr;
        load_chk  = chk;
        sh_data[idx] = data;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Plays one script; optional same-cycle load at start, optional pokes while busy.
    task automatic run(input string tag, input int len, input bit same_load,
                       input logic [7:0] same_data, input bit poke,
                       input logic [7:0] exp_mis, input logic [IDX_W-1:0] exp_first);
        int  nl;
        int  n_play;
        int  n_hold;
        int  last_busy;
        bit  seen_done;
        exp_t e;
        @(negedge clk);
        script_len = (IDX_W+1)'(len);
        start      = 1'b1;
        if (same_load) begin
            load_en   = 1'b1;
            load_idx  = '0;
            load_data = same_data;
            load_chk  = 1'b0;
            sh_data[0] = same_data;
        end
        nl = (len > DEPTH) ? DEPTH : len;
        for (int i = 0; i < nl; i++) exp_q.push_back('{sh_data[i], IDX_W'(i)});
        @(negedge clk);
        start     = 1'b0;
        load_en   = 1'b0;
        n_play    = 0;
        n_hold    = 0;
        last_busy = -1;
        seen_done = 1'b0;
        addr_bus  = cpu_addr[0];
        for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
            load_en = 1'b0;
            start   = 1'b0;
            if (done) begin
                seen_done = 1'b1;
                check({tag, "_done_latency"}, cyc - last_busy, 1);
                check({tag, "_done_data"}, data_out, 0);
                check({tag, "_done_cpu_nrst"}, cpu_nrst, 1);
                check({tag, "_done_busy"}, busy, 0);
            end else begin
                if (busy && !cpu_nrst) begin
                    n_hold++;
                    if (poke && n_hold == 1) begin
                        load_en   = 1'b1;
                        load_idx  = '0;
                        load_data = 8'h55;
                        start     = 1'b1;
                    end
                end else if (busy && cpu_nrst) begin
                    check({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check({tag, "_data"}, data_out, e.data);
                        check({tag, "_step"}, step_idx, e.idx);
                    end
                    n_play++;
                    if (n_play < DEPTH) addr_bus = cpu_addr[n_play];
                end
                if (busy) last_busy = cyc;
            end
            @(negedge clk);
        end
        load_en = 1'b0;
        start   = 1'b0;
        check({tag, "_finished"}, seen_done, 1);
        check({tag, "_hold_cycles"}, n_hold, RST_CY);
        check({tag, "_play_cycles"}, n_play, nl);
        check({tag, "_sb_leftover"}, exp_q.size(), 0);
        check({tag, "_mis_cnt"}, mismatch_cnt, exp_mis);
        check({tag, "_first_mis"}, first_mis_idx, exp_first);
        exp_q.delete();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        nrst       = 1'b0;
        load_en    = 1'b0;
        load_idx   = '0;
        load_data  = '0;
        load_addr  = '0;
        load_chk   = 1'b0;
        script_len = '0;
        start      = 1'b0;
        addr_bus   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sh_data[i]  = '0;
            cpu_addr[i] = '0;
        end

        @(negedge clk);
        check("rst_cpu_nrst", cpu_nrst, 0);
        check("rst_data", data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_step", step_idx, 0);
        check("rst_mis_cnt", mismatch_cnt, 0);
        check("rst_first_mis", first_mis_idx, 5'h1F);
        nrst = 1'b1;

        // Boot vector
        load(0, 8'hDD, 16'h0000, 1'b0);
        load(1, 8'hCC, 16'h0000, 1'b0);
        run("boot", 2, 1'b0, 8'h00, 1'b0, 8'd0, 5'h1F);

        // CMP abs with a matching CPU model
        load(0, 8'hCD, 16'hCCDD, 1'b1);
        load(1, 8'hAA, 16'hCCDE, 1'b1);
        load(2, 8'hAA, 16'hCCDF, 1'b1);
        load(3, 8'h01, 16'hAAAA, 1'b1);
        cpu_addr[0] = 16'hCCDD;
        cpu_addr[1] = 16'hCCDE;
        cpu_addr[2] = 16'hCCDF;
        cpu_addr[3] = 16'hAAAA;
        run("cmp_ok", 4, 1'b0, 8'h00, 1'b0, 8'd0, 5'h1F);

        // Step 2 now expects a different address
        load(2, 8'hAA, 16'h1234, 1'b1);
`ifdef PLAYER_ADDR_CHECK_EN
        run("cmp_mis", 4, 1'b0, 8'h00, 1'b0, 8'd1, 5'd2);
`else
        run("cmp_mis", 4, 1'b0, 8'h00, 1'b0, 8'd0, 5'h1F);
`endif

        // Boundaries: empty script, clamped length with pokes while busy
        run("len0", 0, 1'b0, 8'h00, 1'b0, 8'd0, 5'h1F);
        for (int i = 0; i < DEPTH; i++) load(i, 8'(i * 7 + 3), 16'h0000, 1'b0);
        run("len40", 40, 1'b0, 8'h00, 1'b1, 8'd0, 5'h1F);

        // Same-cycle load and start, then replay from DONE
        run("same_cyc", 3, 1'b1, 8'hA9, 1'b0, 8'd0, 5'h1F);
        run("replay", 3, 1'b0, 8'h00, 1'b0, 8'd0, 5'h1F);

        // Abort mid-PLAY after a mismatch has been recorded
        load(0, 8'h11, 16'h0000, 1'b1);
        load(1, 8'h22, 16'h0000, 1'b1);
        addr_bus = 16'hFFFF;
        @(negedge clk);
        script_len = 6'd4;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20 && !(busy && cpu_nrst); c++) @(negedge clk);
        check("abort_reached_play", busy && cpu_nrst, 1);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        check("abort_cpu_nrst", cpu_nrst, 0);
        check("abort_data", data_out, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_mis_cnt", mismatch_cnt, 0);
        check("abort_first_mis", first_mis_idx, 5'h1F);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check("abort_idle_cpu_nrst", cpu_nrst, 0);
        check("abort_idle_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
